// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : boot-time byte-stream -> instruction-memory word writer
// Rev 1.0
// ============================================================================
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_resetn
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [23:0]           shift_q, shift_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_resetn_q, cpu_resetn_d;

    logic                  accept;
    logic [31:0]           w_word;
    logic [ADDR_WIDTH:0]   w_word_cnt_inc;

    assign in_ready       = (state_q == S_LEN) || (state_q == S_DATA);
    assign accept         = in_valid && in_ready;
    // Newest byte enters at the top, so after four bytes the first one sits in 7:0.
    assign w_word         = {in_data, shift_q};
    assign w_word_cnt_inc = word_cnt_q + (ADDR_WIDTH+1)'(1);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        shift_d     = shift_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    shift_d    = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    shift_d    = w_word[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if ((w_word == 32'd0) || ({1'b0, w_word} > MAX_WORDS)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                            len_d   = w_word[ADDR_WIDTH:0];
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    shift_d    = w_word[31:8];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d     = S_WRITE;
                        mem_addr_d  = 32'({word_cnt_q[ADDR_WIDTH-1:0], 2'b00});
                        mem_wdata_d = w_word;
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = w_word_cnt_inc;
                state_d    = (w_word_cnt_inc == len_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the next-state decode.
        mem_we_d     = (state_d == S_WRITE);
        busy_d       = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
        cpu_resetn_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= 2'd0;
            word_cnt_q   <= '0;
            len_q        <= '0;
            shift_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_resetn_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            len_q        <= len_d;
            shift_q      <= shift_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_resetn_q <= cpu_resetn_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_resetn = cpu_resetn_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader : directed, model-checked bench for imem_loader
// Rev 1.0
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_resetn;

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_resetn (cpu_resetn)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: the bytes accepted in the current load and the count of words written.
    bit          started = 1'b0;
    logic [7:0]  acc[$];
    int          wr_cnt  = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    int          done_cyc  = -1;
    bit          done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input int base);
        return {acc[base+3], acc[base+2], acc[base+1], acc[base]};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (resetn && in_valid && in_ready) acc.push_back(in_data);
    end

    always @(negedge clk) begin
        logic [31:0] n;
        bit hdr, bad, e_we, e_done, e_busy;
        if (!resetn) begin
            started = 1'b0;
            acc.delete();
            wr_cnt  = 0;
        end
        hdr    = started && (acc.size() >= 4);
        n      = hdr ? word_at(0) : 32'd0;
        bad    = hdr && ((n == 32'd0) || (n > 32'd256));
        e_done = hdr && !bad && (32'(wr_cnt) == n);
        e_we   = hdr && !bad && (32'(wr_cnt) < n) && (acc.size() == 4 + 4 * (wr_cnt + 1));
        e_busy = started && !bad && !e_done;
        chk("mem_we",     32'(mem_we),     32'(e_we));
        chk("busy",       32'(busy),       32'(e_busy));
        chk("done",       32'(done),       32'(e_done));
        chk("error",      32'(error),      32'(bad));
        chk("cpu_resetn", 32'(cpu_resetn), 32'(e_done));
        chk("in_ready",   32'(in_ready),   32'(e_busy && !e_we));
        if (!resetn) begin
            chk("rst mem_addr",  mem_addr,  32'd0);
            chk("rst mem_wdata", mem_wdata, 32'd0);
        end
        if (e_we) begin
            chk("mem_addr",  mem_addr,  32'(wr_cnt * 4));
            chk("mem_wdata", mem_wdata, word_at(4 + 4 * wr_cnt));
            wr_cnt++;
        end
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
        end
        if (done && !done_prev) done_cyc = cyc;
        done_prev = done;
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        started  = 1'b1;
        acc.delete();
        wr_cnt   = 0;
    endtask

    // Start while a load is running: must be ignored, model untouched.
    task automatic poke_start();
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget = 0;
        bit hs;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        do begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            budget++;
        end while (!hs && budget < 20);
        if (!hs) chk("handshake timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic wait_flag(input int budget);
        int i = 0;
        in_valid = 1'b0;
        while (!(done || error) && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        if (!(done || error)) chk("wait timeout", 32'd0, 32'd1);
        @(negedge clk); #1;
    endtask

    initial begin
        resetn   = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;

        // Reset with start and in_valid asserted
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready",   32'(in_ready),   32'd0);
        chk("rst cpu_resetn", 32'(cpu_resetn), 32'd0);
        start    = 1'b0;
        in_valid = 1'b0;
        resetn   = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Two-word load, continuous valid
        clear_log();
        pulse_start();
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        wait_flag(50);
        chk("t2 writes",  32'(log_addr.size()), 32'd2);
        chk("t2 addr0",   log_addr[0], 32'h0);
        chk("t2 data0",   log_data[0], 32'h0000_0013);
        chk("t2 addr1",   log_addr[1], 32'h4);
        chk("t2 data1",   log_data[1], 32'h0010_0093);
        chk("t2 spacing", 32'(log_cyc[1] - log_cyc[0]), 32'd5);
        chk("t2 done edge", 32'(done_cyc - log_cyc[1]), 32'd1);
        chk("t2 cpu_resetn", 32'(cpu_resetn), 32'd1);

        // Same image with random gaps and an ignored start mid-load
        clear_log();
        pulse_start();
        send_word(32'd2, 1'b1);
        poke_start();
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h0010_0093, 1'b1);
        wait_flag(200);
        chk("t3 writes", 32'(log_addr.size()), 32'd2);
        chk("t3 data0",  log_data[0], 32'h0000_0013);
        chk("t3 data1",  log_data[1], 32'h0010_0093);

        // Rejected headers: zero, one past depth, upper bits set
        clear_log();
        pulse_start();
        send_word(32'd0, 1'b0);
        wait_flag(20);
        chk("t4 err N=0", 32'(error), 32'd1);
        pulse_start();
        send_word(32'h0000_0101, 1'b0);
        wait_flag(20);
        chk("t4 err N=257", 32'(error), 32'd1);
        chk("t4 cpu_resetn", 32'(cpu_resetn), 32'd0);
        pulse_start();
        send_word(32'h0100_0001, 1'b0);
        wait_flag(20);
        chk("t4 err hi bits", 32'(error), 32'd1);
        chk("t4 no writes", 32'(log_addr.size()), 32'd0);
        pulse_start();
        send_word(32'd1, 1'b0);
        send_word(32'h0000_1237, 1'b0);
        wait_flag(50);
        chk("t4 recover done", 32'(done), 32'd1);
        chk("t4 recover data", log_data[0], 32'h0000_1237);

        // Asynchronous reset mid-word
        clear_log();
        pulse_start();
        send_word(32'd1, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("t5 async busy",     32'(busy),     32'd0);
        chk("t5 async in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5 no writes", 32'(log_addr.size()), 32'd0);
        chk("t5 idle busy", 32'(busy), 32'd0);
        pulse_start();
        send_word(32'd1, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        wait_flag(50);
        chk("t5 addr", log_addr[0], 32'h0);
        chk("t5 data", log_data[0], 32'hDEAD_BEEF);

        // Full depth, then restart from DONE
        clear_log();
        pulse_start();
        send_word(32'd256, 1'b0);
        for (int i = 0; i < 256; i++) send_word((32'(i) * 32'h0101_0101) ^ 32'hA500_0000, 1'b0);
        wait_flag(2000);
        chk("t6 writes",     32'(log_addr.size()), 32'd256);
        chk("t6 last addr",  log_addr[255], 32'h0000_03FC);
        chk("t6 last data",  log_data[255], 32'h5AFF_FFFF);
        chk("t6 done",       32'(done), 32'd1);
        pulse_start();
        @(negedge clk); #1;
        chk("t6 restart cpu_resetn", 32'(cpu_resetn), 32'd0);
        chk("t6 restart busy",       32'(busy),       32'd1);
        clear_log();
        send_word(32'd1, 1'b1);
        send_word(32'hCAFE_F00D, 1'b1);
        wait_flag(200);
        chk("t6 reload data", log_data[0], 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Writes each word to consecutive instruction-memory addresses, the same byte-addressed space the program counter reads. Holds the CPU core in reset until a complete program image has been written.

## Interface

Parameters:
- ADDR_WIDTH, 8, log2 of instruction-memory depth in words; legal image length is 1..2**ADDR_WIDTH words

Ports:
- clk  input  1  system clock, all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE, ERR
- in_valid  input  1  byte on in_data is valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; transfer occurs when in_valid & in_ready
- mem_we  output  1  instruction-memory write strobe, one cycle per word
- mem_addr  output  32  byte address of write = word index << 2
- mem_wdata  output  32  assembled instruction word
- busy  output  1  load in progress (LEN, DATA, WRITE)
- done  output  1  image fully written
- error  output  1  rejected length header
- cpu_resetn  output  1  active-low reset to CPU core; high only in DONE

## Operation

- Stream format: 4-byte little-endian header N (word count), then N words, each 4 bytes little-endian; the first byte of a group lands in bits 7:0.
- States: IDLE, LEN, DATA, WRITE, DONE, ERR.
- IDLE: in_ready=0. start -> LEN; clears byte counter (2 bits), word counter (ADDR_WIDTH+1 bits) and shift register.
- LEN: in_ready=1. Each accepted byte shifts in. On the 4th byte, latch N. If N==0 or N>2**ADDR_WIDTH -> ERR, else -> DATA.
- DATA: in_ready=1. Accept bytes into the word register. On the 4th byte -> WRITE.
- WRITE: in_ready=0, mem_we=1, mem_addr={word_cnt,2'b00} zero-extended to 32 bits, mem_wdata=assembled word. word_cnt increments. If the incremented word_cnt==N -> DONE, else -> DATA.
- DONE: done=1, cpu_resetn=1, in_ready=0. start -> LEN; cpu_resetn drops to 0 on that same edge, and counters clear.
- ERR: error=1, cpu_resetn=0, in_ready=0, mem_we never asserted. start -> LEN.
- start is ignored in LEN, DATA and WRITE. in_valid is ignored whenever in_ready=0.
- Header bits above the compare width still count toward the compare: the full 32-bit N is compared.
- mem_we, mem_addr, mem_wdata, done, error, busy and cpu_resetn are registered outputs, with no combinational path from inputs. in_ready is decoded from registered state only.

## Timing

- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_resetn=0.
- start is sampled on edge k. State is LEN after that edge, and in_ready=1 in cycle k+1.
- With continuous in_valid:
  - Header takes 4 cycles.
  - Each word takes 4 DATA cycles plus 1 WRITE cycle, so mem_we pulses are spaced exactly 5 cycles apart.
- done and cpu_resetn rise on the edge that ends the final WRITE cycle.
- Gaps in in_valid stall the byte counter. No byte is dropped or duplicated.
- Asynchronous reset mid-operation:
  - Immediately forces all outputs to their reset values and discards any partial word.
  - Memory already written is not rewritten.
  - The next load needs a new start.

## Test plan

- Reset check: assert resetn=0 with in_valid=1 and start=1 -> all outputs hold reset values and no byte is accepted.
- Two-word load, continuous valid: bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 -> first mem_we at addr 0x0 with data 0x00000013, second 5 cycles later at addr 0x4 with data 0x00100093; done=1 and cpu_resetn=1 on the next edge.
- Backpressure and gaps: same stream with in_valid toggling randomly -> identical writes; in_ready=0 during each WRITE cycle; exactly 2 mem_we pulses.
- Bad header: N=0, then N=0x00000101 with ADDR_WIDTH=8 -> error=1, no mem_we, cpu_resetn=0; a following start with a valid image completes normally.
- Reset mid-word: load N=1, deassert resetn after 2 data bytes -> no mem_we, state IDLE; restart with start loads 0xDEADBEEF (bytes EF BE AD DE) at addr 0.
- Full depth and reload: N=256 -> last write at addr 0x3FC, done=1; a start in DONE drops cpu_resetn the same edge and sets busy=1.
